// File: rtl/reg_file_mp.sv
// Multi-port register file with load scoreboard: two write ports, NR combinational read ports.
// Optional same-cycle write-to-read bypass is built when REG_FILE_MP_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int W  = 8,
  parameter int D  = 3,
  parameter int NR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NR*D-1:0] raddr,
  output logic [NR*W-1:0] rdata,
  output logic [NR-1:0]   rbusy,
  input  logic            wa_en,
  input  logic [D-1:0]    wa_addr,
  input  logic [W-1:0]    wa_data,
  input  logic            wb_en,
  input  logic [D-1:0]    wb_addr,
  input  logic [W-1:0]    wb_data,
  input  logic            mark_en,
  input  logic [D-1:0]    mark_addr,
  output logic [2**D-1:0] pending,
  output logic            waw_err
);

  localparam int N = 2**D;

  logic [W-1:0] regs_q [N];
  logic [N-1:0] pending_q, pending_d;
  logic         waw_err_q;
  logic         wb_write;

  // Port A owns the address when both ports collide; B's data is dropped.
  assign wb_write = wb_en && !(wa_en && (wa_addr == wb_addr));

  // Load return clears, load issue sets; a same-cycle mark wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (mark_en) begin
      pending_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        regs_q[r] <= '0;
      end
      pending_q <= '0;
      waw_err_q <= 1'b0;
    end else begin
      if (wa_en) begin
        regs_q[wa_addr] <= wa_data;
      end
      if (wb_write) begin
        regs_q[wb_addr] <= wb_data;
      end
      pending_q <= pending_d;
      if (wa_en && pending_q[wa_addr]) begin
        waw_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      rdata[i*W +: W] = regs_q[raddr[i*D +: D]];
`ifdef REG_FILE_MP_BYPASS_EN
      if (!reset) begin
        if (wa_en && (wa_addr == raddr[i*D +: D])) begin
          rdata[i*W +: W] = wa_data;
        end else if (wb_en && (wb_addr == raddr[i*D +: D])) begin
          rdata[i*W +: W] = wb_data;
        end
      end
`endif
      // A load returning this cycle no longer blocks the reader.
      rbusy[i] = pending_q[raddr[i*D +: D]] && !(wb_en && (wb_addr == raddr[i*D +: D]));
    end
  end

  assign pending = pending_q;
  assign waw_err = waw_err_q;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter D, default 3, meaning address width; depth is 2**D registers.
REQ-003 The block SHALL have parameter NR, default 2, meaning the number of read ports.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: clk, reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 raddr  input  NR*D  packed read addresses; port i uses bits [i*D +: D].
REQ-008 rdata  output  NR*W  packed read data; port i uses bits [i*W +: W].
REQ-009 rbusy  output  NR  port i's register has a load outstanding.
REQ-010 wa_en / wa_addr / wa_data  input  1 / D / W  write port A (ALU results).
REQ-011 wb_en / wb_addr / wb_data  input  1 / D / W  write port B (load return).
REQ-012 mark_en / mark_addr  input  1 / D  marks a register pending when a load issues.
REQ-013 pending  output  2**D  scoreboard vector, bit r = register r pending.
REQ-014 waw_err  output  1  sticky flag: port A wrote a pending register.

Function
REQ-015 Reads SHALL be combinational: rdata port i = Registers[raddr i], with bypass per REQ-024.
REQ-016 Writes SHALL take effect at the rising clk edge in the cycle their enable is high.
REQ-017 If wa_en and wb_en target the same address in one cycle, port A's data SHALL be written and port B's data discarded.
REQ-018 If wa_en and wb_en target different addresses, both SHALL be written in the same cycle.
REQ-019 mark_en SHALL set pending[mark_addr] at the next edge.
REQ-020 wb_en SHALL clear pending[wb_addr] at the next edge, including when its data is discarded per REQ-017.
REQ-021 If mark_en and wb_en target the same address in one cycle, the pending bit SHALL end set (mark wins).
REQ-022 rbusy[i] SHALL be combinational: pending[raddr i] AND NOT (wb_en AND wb_addr equals raddr i).
REQ-023 wa_en to an address whose pending bit is set SHALL still write, leave pending unchanged, and set waw_err at the next edge; waw_err SHALL stay set until reset.

Reset
REQ-025 reset high at an edge SHALL clear all registers to 0, pending to 0 and waw_err to 0, overriding every write, mark and clear in that cycle.
REQ-026 While reset is high, rdata SHALL still reflect the current array contents, and bypass SHALL be suppressed.
REQ-027 The first edge with reset low SHALL accept writes and marks normally.

Configuration
REQ-024 With macro REG_FILE_MP_BYPASS_EN defined, a read whose address matches an enabled write in the same cycle SHALL return that write's data combinationally, with port A taking priority over port B. Without the macro, reads SHALL return the pre-edge array value and no bypass logic SHALL exist.

Verification
REQ-028 Reset, then read all 8 registers -> every rdata = 0x00, pending = 0x00, waw_err = 0.
REQ-029 wa_en, wa_addr=3, wa_data=0xA5 with raddr0=3 in the same cycle -> with bypass, rdata0 = 0xA5 that cycle; without bypass, rdata0 = 0x00 that cycle and 0xA5 the next.
REQ-030 wa and wb in the same cycle, both addr=5, wa_data=0x11, wb_data=0x22, pending[5]=1 -> Register5 = 0x11, pending[5] = 0, waw_err = 1.
REQ-031 mark_en addr=2, then wb_en addr=2 with mark_en addr=2 in the same cycle -> pending[2] stays 1; rbusy for raddr=2 = 0 during the wb cycle and 1 after it.
REQ-032 mark addr=6; next cycle assert reset together with wb_en addr=6, wb_data=0x7F -> Register6 = 0x00, pending = 0x00.
REQ-033 Two-port read with raddr0=1, raddr1=1 after writing 0x3C to register 1 -> both rdata ports = 0x3C, and both rbusy bits equal.
